// File: rtl/inst_fetch_pkg.sv
// Shared types and helpers for the dual-issue instruction fetch unit.
//   pc_t / inst_t    : 32-bit program-counter and instruction words
//   pair_t           : {word at addr+4, word at addr} as returned by memory
//   RESET_PC_DEFAULT : default first fetch address after reset
//   pair_base()      : 8-byte-aligned base of the pair holding a PC
package inst_fetch_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  typedef logic [PC_W-1:0]     pc_t;
  typedef logic [INST_W-1:0]   inst_t;
  typedef logic [2*INST_W-1:0] pair_t;

  localparam pc_t RESET_PC_DEFAULT = 32'h0000_0000;

  // Address of the aligned instruction pair containing pc.
  function automatic pc_t pair_base(input pc_t pc);
    return {pc[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bus bundle of the fetch unit: control inputs (stall, buffer full,
// branch redirect), the synchronous instruction-memory read port and the
// two-slot write side of the IF/ID instruction buffer.
//   master : the fetch unit
//   slave  : the environment (memory, buffer, pipeline control)
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic  stop;
  logic  instbuf_full;
  logic  branch_flag;
  pc_t   branch_pc;

  logic  imem_en;
  pc_t   imem_addr;
  pair_t imem_rdata;

  logic  if1_valid;
  inst_t if1_inst;
  pc_t   if1_pc;
  pc_t   if1_npc;
  logic  if2_valid;
  inst_t if2_inst;
  pc_t   if2_pc;
  pc_t   if2_npc;

  modport master (
    input  stop, instbuf_full, branch_flag, branch_pc, imem_rdata,
    output imem_en, imem_addr,
    output if1_valid, if1_inst, if1_pc, if1_npc,
    output if2_valid, if2_inst, if2_pc, if2_npc
  );

  modport slave (
    output stop, instbuf_full, branch_flag, branch_pc, imem_rdata,
    input  imem_en, imem_addr,
    input  if1_valid, if1_inst, if1_pc, if1_npc,
    input  if2_valid, if2_inst, if2_pc, if2_npc
  );

endinterface

// File: rtl/inst_fetch_align.sv
// Slot selector for the fetched pair (the inst_align stage): maps the
// pair returned by memory onto the two buffer slots and forms each
// slot's predicted next PC (pc+4, wrapping mod 2^32).
//   pair_valid : a fetched pair is present and not being squashed
//   f2_pc      : fetch address of that pair (bit 2 set => odd-word entry)
//   rdata      : {word at base+4, word at base}
//   if1_* / if2_* : slot outputs toward the instruction buffer
module inst_fetch_align
  import inst_fetch_pkg::*;
(
  input  logic  pair_valid,
  input  pc_t   f2_pc,
  input  pair_t rdata,
  output logic  if1_valid,
  output inst_t if1_inst,
  output pc_t   if1_pc,
  output pc_t   if1_npc,
  output logic  if2_valid,
  output inst_t if2_inst,
  output pc_t   if2_pc,
  output pc_t   if2_npc
);

  // Slot selection: an odd-word entry point only yields the high word.
  always_comb begin
    if1_valid = pair_valid;
    if1_pc    = f2_pc;
    if2_inst  = rdata[63:32];
    if2_pc    = pair_base(f2_pc) + 32'd4;
    if (f2_pc[2]) begin
      if1_inst  = rdata[63:32];
      if2_valid = 1'b0;
    end else begin
      if1_inst  = rdata[31:0];
      if2_valid = pair_valid;
    end
    if1_npc = if1_pc + 32'd4;
    if2_npc = if2_pc + 32'd4;
  end

endmodule

// File: rtl/inst_fetch.sv
// Dual-issue instruction fetch unit. Issues an aligned 8-byte read each
// cycle it can advance, holds the returned pair until the instruction
// buffer accepts it, and squashes/redirects on a branch.
//   clk, rst : clock and asynchronous active-low reset
//   fif      : master side of inst_fetch_if (control, memory, buffer slots)
//   RESET_PC : first fetch address after reset
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter pc_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master fif
);

  pc_t  fetch_pc_r;
  logic f2_valid_r;
  pc_t  f2_pc_r;

  logic advance_s;
  logic issue_s;
  logic pair_valid_s;

  // Advance control. The held pair only blocks on full when it exists;
  // the read port stays idle during reset and on a redirect cycle.
  always_comb begin
    advance_s    = !fif.stop && !(f2_valid_r && fif.instbuf_full);
    issue_s      = rst && advance_s && !fif.branch_flag;
    pair_valid_s = f2_valid_r && !fif.branch_flag;
  end

  assign fif.imem_en   = issue_s;
  assign fif.imem_addr = pair_base(fetch_pc_r);

  // Fetch PC and second-stage pair registers; branch beats any stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_r <= RESET_PC;
      f2_valid_r <= 1'b0;
      f2_pc_r    <= 32'h0000_0000;
    end else if (fif.branch_flag) begin
      fetch_pc_r <= {fif.branch_pc[31:2], 2'b00};
      f2_valid_r <= 1'b0;
      f2_pc_r    <= f2_pc_r;
    end else if (advance_s) begin
      fetch_pc_r <= pair_base(fetch_pc_r) + 32'd8;
      f2_valid_r <= 1'b1;
      f2_pc_r    <= fetch_pc_r;
    end else begin
      fetch_pc_r <= fetch_pc_r;
      f2_valid_r <= f2_valid_r;
      f2_pc_r    <= f2_pc_r;
    end
  end

  inst_fetch_align u_align (
    .pair_valid (pair_valid_s),
    .f2_pc      (f2_pc_r),
    .rdata      (fif.imem_rdata),
    .if1_valid  (fif.if1_valid),
    .if1_inst   (fif.if1_inst),
    .if1_pc     (fif.if1_pc),
    .if1_npc    (fif.if1_npc),
    .if2_valid  (fif.if2_valid),
    .if2_inst   (fif.if2_inst),
    .if2_pc     (fif.if2_pc),
    .if2_npc    (fif.if2_npc)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: synchronous memory model whose word at
// address a is 32'h1000_0000 + a/4, a buffer-write counter, and a linear
// sequence of steps with hand-computed expected values.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  int   wr_cnt;
  int   cnt16;
  int   wc_hold;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .fif (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic inst_t mem_word(input pc_t a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Synchronous instruction memory; output holds while not enabled.
  always_ff @(posedge clk) begin
    if (bus.imem_en) begin
      bus.imem_rdata <= {mem_word(bus.imem_addr + 32'd4), mem_word(bus.imem_addr)};
    end
  end

  // Buffer write monitor.
  always @(posedge clk) begin
    if (rst && bus.if1_valid && !bus.instbuf_full && !bus.stop) begin
      wr_cnt = wr_cnt + 1;
      if (bus.if1_pc == 32'd16) cnt16 = cnt16 + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pair(input string tag, input pc_t p1, input logic v2, input pc_t p2);
    chk({tag, " v1"}, {31'd0, bus.if1_valid}, 32'd1);
    chk({tag, " pc1"}, bus.if1_pc, p1);
    chk({tag, " inst1"}, bus.if1_inst, mem_word(p1));
    chk({tag, " npc1"}, bus.if1_npc, p1 + 32'd4);
    chk({tag, " v2"}, {31'd0, bus.if2_valid}, {31'd0, v2});
    if (v2) begin
      chk({tag, " pc2"}, bus.if2_pc, p2);
      chk({tag, " inst2"}, bus.if2_inst, mem_word(p2));
      chk({tag, " npc2"}, bus.if2_npc, p2 + 32'd4);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic en, input pc_t addr, input logic v1);
    chk({tag, " en"}, {31'd0, bus.imem_en}, {31'd0, en});
    chk({tag, " addr"}, bus.imem_addr, addr);
    chk({tag, " v1"}, {31'd0, bus.if1_valid}, {31'd0, v1});
    if (!v1) chk({tag, " v2"}, {31'd0, bus.if2_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fails = 0; wr_cnt = 0; cnt16 = 0; wc_hold = 0;
    rst = 1'b0;
    bus.stop = 1'b0; bus.instbuf_full = 1'b0;
    bus.branch_flag = 1'b0; bus.branch_pc = 32'h0000_0000;

    // Reset state
    repeat (2) cyc();
    @(negedge clk);
    chk_ctl("reset", 1'b0, 32'h0, 1'b0);

    // Cycle 0: first issue at RESET_PC
    cyc(); rst = 1'b1; @(negedge clk);
    chk_ctl("c0", 1'b1, 32'h0, 1'b0);
    // Cycles 1,2: two instructions per cycle
    cyc(); @(negedge clk);
    chk_pair("c1", 32'd0, 1'b1, 32'd4);
    chk_ctl("c1", 1'b1, 32'd8, 1'b1);
    chk("c1 inst1 const", bus.if1_inst, 32'h1000_0000);
    cyc(); @(negedge clk);
    chk_pair("c2", 32'd8, 1'b1, 32'd12);

    // Cycles 3-5: buffer full, pair 16/20 held stable
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.instbuf_full = 1'b1; @(negedge clk);
      chk_pair("full", 32'd16, 1'b1, 32'd20);
      chk_ctl("full", 1'b0, 32'd24, 1'b1);
    end
    // Cycle 6: full drops, held pair written and next issued
    cyc(); bus.instbuf_full = 1'b0; @(negedge clk);
    chk_pair("c6", 32'd16, 1'b1, 32'd20);
    chk_ctl("c6", 1'b1, 32'd24, 1'b1);
    cyc(); @(negedge clk);
    chk_pair("c7", 32'd24, 1'b1, 32'd28);
    chk("c7 pc16 writes", cnt16, 32'd1);

    // Cycle 8: redirect to odd-word target 0x104
    cyc(); bus.branch_flag = 1'b1; bus.branch_pc = 32'h0000_0104; @(negedge clk);
    chk_ctl("br", 1'b0, 32'd40, 1'b0);
    cyc(); bus.branch_flag = 1'b0; @(negedge clk);
    chk_ctl("br+1", 1'b1, 32'h100, 1'b0);
    cyc(); @(negedge clk);
    chk_pair("br+2", 32'h104, 1'b0, 32'h0);
    chk("br+2 inst const", bus.if1_inst, 32'h1000_0041);
    chk_ctl("br+2", 1'b1, 32'h108, 1'b1);
    cyc(); @(negedge clk);
    chk_pair("br+3", 32'h108, 1'b1, 32'h10C);

    // Cycle 12: stop and full with pair 0x110 present
    cyc(); bus.instbuf_full = 1'b1; bus.stop = 1'b1; @(negedge clk);
    chk_pair("stall", 32'h110, 1'b1, 32'h114);
    chk_ctl("stall", 1'b0, 32'h118, 1'b1);
    wc_hold = wr_cnt;
    // Cycle 13: branch coincident with full and stop
    cyc(); bus.branch_flag = 1'b1; bus.branch_pc = 32'hFFFF_FFFA; @(negedge clk);
    chk_ctl("br stall", 1'b0, 32'h118, 1'b0);
    cyc(); bus.branch_flag = 1'b0; bus.instbuf_full = 1'b0; @(negedge clk);
    chk_ctl("stop only", 1'b0, 32'hFFFF_FFF8, 1'b0);
    cyc(); bus.stop = 1'b0; @(negedge clk);
    chk_ctl("resume", 1'b1, 32'hFFFF_FFF8, 1'b0);
    chk("dropped pair writes", wr_cnt, wc_hold);

    // Wrap at top of address space
    cyc(); @(negedge clk);
    chk_pair("wrap", 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFFC);
    chk("wrap npc2", bus.if2_npc, 32'h0000_0000);
    chk("wrap inst2", bus.if2_inst, 32'h4FFF_FFFF);
    chk_ctl("wrap", 1'b1, 32'h0, 1'b1);
    cyc(); @(negedge clk);
    chk_pair("wrap+1", 32'h0, 1'b1, 32'h4);

    // Reset mid-stream with a pair present
    cyc(); @(negedge clk);
    chk_pair("pre-rst", 32'h8, 1'b1, 32'hC);
    cyc(); rst = 1'b0; #1;
    chk_ctl("rst mid", 1'b0, 32'h0, 1'b0);
    cyc(); rst = 1'b1; @(negedge clk);
    chk_ctl("rst rel", 1'b1, 32'h0, 1'b0);
    cyc(); @(negedge clk);
    chk_pair("refetch", 32'h0, 1'b1, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
